// File: rtl/jtcop_mapsel_decoder.sv
// jtcop_mapsel_decoder
// Tile-map bank decoder with a hidden "map select" counter and a runtime-loaded
// lookup table that maps each (slot, mapsel) pair to one of NCS chip selects.
// The CPU advances the counter by reading UP_SLOT and resets it by writing
// CLR_SLOT. Optionally, the counter also clears at the start of vertical blank.

module jtcop_mapsel_decoder #(
  parameter int              SW        = 3,
  parameter int              MW        = 2,
  parameter int              NCS       = 6,
  parameter int              UP_SLOT   = 2,
  parameter int              CLR_SLOT  = 5,
  parameter int              WRAP      = 1,
  parameter int              AUTOCLR   = 0,
  parameter logic [NCS-1:0]  DISP_MASK = {NCS{1'b1}},
  localparam int             CW        = $clog2(NCS+1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_win_cs,
  input  logic [SW-1:0]    i_slot,
  input  logic             i_RnW,
  input  logic             i_LVBL,
  input  logic             i_cfg_we,
  input  logic [SW+MW-1:0] i_cfg_addr,
  input  logic [CW-1:0]    i_cfg_din,
  output logic [CW-1:0]    o_cfg_dout,
  output logic [NCS-1:0]   o_cs,
  output logic             o_disp_cs,
  output logic [MW-1:0]    o_mapsel
);

  localparam int             DEPTH  = 1 << (SW + MW);
  localparam logic [MW-1:0]  MS_MAX = '1;

  logic [CW-1:0]  r_table [DEPTH];
  logic [MW-1:0]  r_mapsel;
  logic           r_up_l;
  logic           r_clr_l;
  logic           r_lvbl_l;

  logic           w_up;
  logic           w_clr;
  logic           w_up_edge;
  logic           w_clr_edge;
  logic           w_auto_edge;
  logic [MW-1:0]  w_mapsel_nxt;
  logic           w_hit;
  logic [CW-1:0]  w_code;
  logic [NCS-1:0] w_cs;

  // Special-slot accesses and their rising edges
  assign w_up        = i_win_cs & (i_slot == SW'(UP_SLOT))  &  i_RnW;
  assign w_clr       = i_win_cs & (i_slot == SW'(CLR_SLOT)) & ~i_RnW;
  assign w_up_edge   = w_up  & ~r_up_l;
  assign w_clr_edge  = w_clr & ~r_clr_l;
  assign w_auto_edge = (AUTOCLR != 0) & ~i_LVBL & r_lvbl_l;

  // Lookup table: cleared only by reset, one entry written per clock
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (i_cfg_we) begin
      r_table[i_cfg_addr] <= i_cfg_din;
    end
  end

  // Edge-detect history for the count-up, clear and vertical-blank strobes
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      r_up_l   <= 1'b0;
      r_clr_l  <= 1'b0;
      r_lvbl_l <= 1'b0;
    end else begin
      r_up_l   <= w_up;
      r_clr_l  <= w_clr;
      r_lvbl_l <= i_LVBL;
    end
  end

  // Next counter value: any clear source beats an increment in the same cycle
  always_comb begin
    w_mapsel_nxt = r_mapsel;
    if (w_clr_edge || w_auto_edge) begin
      w_mapsel_nxt = '0;
    end else if (w_up_edge) begin
      if (r_mapsel == MS_MAX) w_mapsel_nxt = (WRAP != 0) ? '0 : MS_MAX;
      else                    w_mapsel_nxt = r_mapsel + 1'b1;
    end
  end

  // Map select counter register
  always_ff @(posedge clk, posedge rst) begin
    if (rst) r_mapsel <= '0;
    else     r_mapsel <= w_mapsel_nxt;
  end

  // Chip-select decode; the counter slots never select a chip
  assign w_hit  = i_win_cs & (i_slot != SW'(UP_SLOT)) & (i_slot != SW'(CLR_SLOT));
  assign w_code = r_table[{i_slot, r_mapsel}];

  // One-hot decode of the table code, out-of-range codes select nothing
  always_comb begin
    w_cs = '0;
    if (w_hit) begin
      for (int k = 0; k < NCS; k++) begin
        if (w_code == CW'(k + 1)) w_cs[k] = 1'b1;
      end
    end
  end

  assign o_cs       = w_cs;
  assign o_disp_cs  = |(w_cs & DISP_MASK);
  assign o_mapsel   = r_mapsel;
  assign o_cfg_dout = r_table[i_cfg_addr];

endmodule

// File: tb/tb_jtcop_mapsel_decoder.sv
// tb_jtcop_mapsel_decoder
// Two decoders share every input: dutA uses the default parameters, dutB
// saturates, auto-clears on vertical blank and masks cs[0] out of disp_cs.

module tb_jtcop_mapsel_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       winCs;
  logic [2:0] slot;
  logic       rnw;
  logic       lvbl;
  logic       cfgWe;
  logic [4:0] cfgAddr;
  logic [2:0] cfgDin;

  logic [2:0] doutA, doutB;
  logic [5:0] csA, csB;
  logic       dispA, dispB;
  logic [1:0] msA, msB;

  int nChecks = 0;
  int nPass   = 0;

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  jtcop_mapsel_decoder dutA (
    .clk(clk), .rst(rst), .i_win_cs(winCs), .i_slot(slot), .i_RnW(rnw),
    .i_LVBL(lvbl), .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr), .i_cfg_din(cfgDin),
    .o_cfg_dout(doutA), .o_cs(csA), .o_disp_cs(dispA), .o_mapsel(msA)
  );

  jtcop_mapsel_decoder #(
    .WRAP(0), .AUTOCLR(1), .DISP_MASK(6'b111110)
  ) dutB (
    .clk(clk), .rst(rst), .i_win_cs(winCs), .i_slot(slot), .i_RnW(rnw),
    .i_LVBL(lvbl), .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr), .i_cfg_din(cfgDin),
    .o_cfg_dout(doutB), .o_cs(csB), .o_disp_cs(dispB), .o_mapsel(msB)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the CPU-side access inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic w, input logic [2:0] s, input logic r);
    winCs = w;
    slot  = s;
    rnw   = r;
    #1;
  endtask

  // Load one table entry through the config port
  task automatic writeEntry(input logic [4:0] a, input logic [2:0] d);
    cfgWe   = 1'b1;
    cfgAddr = a;
    cfgDin  = d;
    tick();
    cfgWe   = 1'b0;
  endtask

  // One isolated read of the count-up slot
  task automatic pulseUp();
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
  endtask

  // Counter values of both instances in one step
  task automatic checkMs(input string tag, input logic [1:0] expA, input logic [1:0] expB);
    checkOutput({tag, "_msA"}, 32'(msA), 32'(expA));
    checkOutput({tag, "_msB"}, 32'(msB), 32'(expB));
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; winCs = 1'b0; slot = '0; rnw = 1'b1; lvbl = 1'b1;
    cfgWe = 1'b0; cfgAddr = '0; cfgDin = '0;
    repeat (3) tick();

    checkMs("reset", 2'd0, 2'd0);
    checkOutput("reset_csA", 32'(csA), 32'h0);
    checkOutput("reset_doutA", 32'(doutA), 32'h0);
    rst = 1'b0;
    tick();

    // Table: {slot0,ms0..3} = 1,3,5,2 ; {slot1,ms0} = 7 (out of range)
    writeEntry(5'b000_00, 3'd1);
    writeEntry(5'b000_01, 3'd3);
    writeEntry(5'b000_10, 3'd5);
    writeEntry(5'b000_11, 3'd2);
    writeEntry(5'b001_00, 3'd7);
    cfgAddr = 5'b000_00;
    #1;
    checkOutput("dout_idx0", 32'(doutA), 32'd1);

    applyStimulus(1'b1, 3'd0, 1'b1);
    checkOutput("slot0_csA", 32'(csA), 32'b000001);
    checkOutput("slot0_dispA", 32'(dispA), 32'd1);
    checkOutput("slot0_csB", 32'(csB), 32'b000001);
    checkOutput("slot0_dispB_masked", 32'(dispB), 32'd0);

    applyStimulus(1'b1, 3'd1, 1'b1);
    checkOutput("code7_csA", 32'(csA), 32'h0);
    checkOutput("code7_dispA", 32'(dispA), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("nowin_csA", 32'(csA), 32'h0);
    tick();

    // Long read of UP_SLOT counts exactly once
    applyStimulus(1'b1, 3'd2, 1'b1);
    checkOutput("upslot_csA", 32'(csA), 32'h0);
    repeat (10) tick();
    checkOutput("upslot_hold_csA", 32'(csA), 32'h0);
    checkMs("longup", 2'd1, 2'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd0, 1'b1);
    checkOutput("ms1_csA", 32'(csA), 32'b000100);
    checkOutput("ms1_csB", 32'(csB), 32'b000100);
    checkOutput("ms1_dispB", 32'(dispB), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();

    // Wrap versus saturate
    pulseUp(); checkMs("up2", 2'd2, 2'd2);
    pulseUp(); checkMs("up3", 2'd3, 2'd3);
    pulseUp(); checkMs("up4", 2'd0, 2'd3);
    pulseUp(); checkMs("up5", 2'd1, 2'd3);
    pulseUp(); pulseUp(); checkMs("up7", 2'd3, 2'd3);

    // Read of CLR_SLOT and write of UP_SLOT do nothing
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("clrslot_csA", 32'(csA), 32'h0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkMs("rdclr", 2'd3, 2'd3);
    applyStimulus(1'b1, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();
    checkMs("wrup", 2'd3, 2'd3);

    // Write of CLR_SLOT clears on the next edge
    applyStimulus(1'b1, 3'd5, 1'b0);
    checkMs("wrclr_pre", 2'd3, 2'd3);
    tick();
    checkMs("wrclr", 2'd0, 2'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();

    // Auto-clear on LVBL falling edge (dutB only)
    pulseUp(); pulseUp();
    checkMs("pre_lvbl", 2'd2, 2'd2);
    lvbl = 1'b0;
    tick();
    checkMs("lvbl_fall", 2'd2, 2'd0);
    lvbl = 1'b1;
    tick();
    pulseUp(); pulseUp();
    checkMs("pre_coinc", 2'd0, 2'd2);
    lvbl = 1'b0;
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    checkMs("coinc", 2'd1, 2'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    lvbl = 1'b1;
    tick();

    // Table write is visible to cs the cycle after the write edge
    applyStimulus(1'b1, 3'd0, 1'b1);
    cfgWe = 1'b1; cfgAddr = 5'b000_00; cfgDin = 3'd4;
    #1;
    checkOutput("prewr_csB", 32'(csB), 32'b000001);
    tick();
    cfgWe = 1'b0;
    #1;
    checkOutput("postwr_csB", 32'(csB), 32'b001000);
    checkOutput("postwr_csA", 32'(csA), 32'b000100);

    // Asynchronous reset in the middle of an access
    rst = 1'b1;
    #1;
    checkOutput("rst_csA", 32'(csA), 32'h0);
    checkOutput("rst_csB", 32'(csB), 32'h0);
    checkMs("rst_async", 2'd0, 2'd0);
    checkOutput("rst_doutB", 32'(doutB), 32'h0);

    // Held count-up read across reset release counts as a fresh edge
    applyStimulus(1'b1, 3'd2, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    checkMs("rst_hold", 2'd0, 2'd0);
    tick();
    checkMs("rst_fresh", 2'd1, 2'd1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
